// File: rtl/pt_feedback_pkg.sv
// Shared definitions for the pt_feedback output path: ramp state encoding and
// helpers that derive the DAC saturation bounds from the output width.
package pt_feedback_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ramp_state_e;

    // Largest and smallest two's-complement values of an ow-bit sample.
    function automatic longint sat_hi(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

endpackage

// File: rtl/soft_enable_ramp.sv
// Soft-enable ramp: walks the gain factor R linearly between 0 and 2^RAMP_BITS
// so that toggling feedback never steps the DAC.
module soft_enable_ramp
    import pt_feedback_pkg::*;
#(
    parameter int RAMP_BITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [3:0]         ramp_rate_i,
    output logic [RAMP_BITS:0] r_o,
    output ramp_state_e        state_o
);

    localparam int                 PRE_W  = 15;
    localparam logic [RAMP_BITS:0] R_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [RAMP_BITS:0] R_ONE  = {{RAMP_BITS{1'b0}}, 1'b1};

    ramp_state_e        state_q;
    logic [RAMP_BITS:0] r_q;
    logic [PRE_W-1:0]   pre_q;
    logic [3:0]         rate_q;
    logic [PRE_W-1:0]   pre_max;
    logic               tick;

    // The rate is latched only when the prescaler restarts, so a live change
    // mid-ramp takes effect from the next wrap.
    assign pre_max = {PRE_W{1'b1}} >> (4'd15 - rate_q);
    assign tick    = (pre_q == pre_max);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            r_q     <= '0;
            pre_q   <= '0;
            rate_q  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register in this block sees the pre-edge values of the others.
            case (state_q)
                ST_OFF: begin
                    pre_q  <= '0;
                    rate_q <= ramp_rate_i;
                    if (enable_i) state_q <= ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!enable_i) begin
                        state_q <= ST_RAMP_DOWN;
                        pre_q   <= '0;
                        rate_q  <= ramp_rate_i;
                    end else if (r_q == R_FULL) begin
                        state_q <= ST_ON;
                        pre_q   <= '0;
                        rate_q  <= ramp_rate_i;
                    end else if (tick) begin
                        r_q    <= r_q + 1'b1;
                        pre_q  <= '0;
                        rate_q <= ramp_rate_i;
                        if (r_q == R_FULL - 1'b1) state_q <= ST_ON;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
                ST_ON: begin
                    pre_q  <= '0;
                    rate_q <= ramp_rate_i;
                    if (!enable_i) state_q <= ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (enable_i) begin
                        state_q <= ST_RAMP_UP;
                        pre_q   <= '0;
                        rate_q  <= ramp_rate_i;
                    end else if (r_q == '0) begin
                        state_q <= ST_OFF;
                        pre_q   <= '0;
                        rate_q  <= ramp_rate_i;
                    end else if (tick) begin
                        r_q    <= r_q - 1'b1;
                        pre_q  <= '0;
                        rate_q <= ramp_rate_i;
                        if (r_q == R_ONE) state_q <= ST_OFF;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign r_o     = r_q;
    assign state_o = state_q;

endmodule

// File: rtl/feedback_output_stage.sv
// pt_feedback output stage: gain, arithmetic shift, DAC saturation and soft
// enable ramp, four registered stages with no stall, plus a clip counter.
module feedback_output_stage
    import pt_feedback_pkg::*;
#(
    parameter int INPUT_WIDTH   = 17,
    parameter int GAIN_WIDTH    = 16,
    parameter int OUTPUT_WIDTH  = 14,
    parameter int RAMP_BITS     = 8,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic signed [INPUT_WIDTH-1:0]   data_i,
    input  logic signed [GAIN_WIDTH-1:0]    gain_i,
    input  logic        [3:0]               shift_i,
    input  logic                            enable_i,
    input  logic        [3:0]               ramp_rate_i,
    input  logic                            sat_clr_i,
    output logic signed [OUTPUT_WIDTH-1:0]  data_o,
    output logic                            sat_o,
    output logic        [SAT_CNT_WIDTH-1:0] sat_cnt_o,
    output logic        [1:0]               state_o
);

    localparam int PROD_WIDTH      = INPUT_WIDTH + GAIN_WIDTH;
    localparam int RAMP_PROD_WIDTH = OUTPUT_WIDTH + RAMP_BITS + 2;
    localparam logic signed [PROD_WIDTH-1:0] SAT_HI = PROD_WIDTH'(sat_hi(OUTPUT_WIDTH));
    localparam logic signed [PROD_WIDTH-1:0] SAT_LO = PROD_WIDTH'(sat_lo(OUTPUT_WIDTH));

    logic signed [INPUT_WIDTH-1:0]     data_s1_q;
    logic signed [GAIN_WIDTH-1:0]      gain_s1_q;
    logic        [3:0]                 shift_s1_q, shift_s2_q;
    logic signed [PROD_WIDTH-1:0]      prod_s2_q, prod_s2_d;
    logic signed [PROD_WIDTH-1:0]      shifted;
    logic signed [OUTPUT_WIDTH-1:0]    q_s3_q, q_s3_d;
    logic                              clip_s3_q, clip_s3_d;
    logic signed [RAMP_PROD_WIDTH-1:0] ramp_prod;
    logic signed [OUTPUT_WIDTH-1:0]    y_s4_q, y_s4_d;
    logic                              sat_s4_q;
    logic        [SAT_CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;
    logic        [RAMP_BITS:0]         ramp_r;
    ramp_state_e                       ramp_state;

    soft_enable_ramp #(
        .RAMP_BITS (RAMP_BITS)
    ) u_ramp (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .ramp_rate_i (ramp_rate_i),
        .r_o         (ramp_r),
        .state_o     (ramp_state)
    );

    always_comb begin
        // NOTE: every combinational output is given a default first so that no
        // path through the block can infer a latch.
        prod_s2_d = PROD_WIDTH'(data_s1_q) * PROD_WIDTH'(gain_s1_q);
        shifted   = prod_s2_q >>> shift_s2_q;
        q_s3_d    = OUTPUT_WIDTH'(shifted);
        clip_s3_d = 1'b0;
        if (shifted > SAT_HI) begin
            q_s3_d    = OUTPUT_WIDTH'(SAT_HI);
            clip_s3_d = 1'b1;
        end else if (shifted < SAT_LO) begin
            q_s3_d    = OUTPUT_WIDTH'(SAT_LO);
            clip_s3_d = 1'b1;
        end

        // R is unsigned; the zero bit keeps the ramp product signed on q only.
        ramp_prod = RAMP_PROD_WIDTH'(q_s3_q) * RAMP_PROD_WIDTH'($signed({1'b0, ramp_r}));
        y_s4_d    = OUTPUT_WIDTH'(ramp_prod >>> RAMP_BITS);

        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (clip_s3_q && (ramp_state != ST_OFF) && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_s1_q  <= '0;
            gain_s1_q  <= '0;
            shift_s1_q <= '0;
            prod_s2_q  <= '0;
            shift_s2_q <= '0;
            q_s3_q     <= '0;
            clip_s3_q  <= 1'b0;
            y_s4_q     <= '0;
            sat_s4_q   <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            data_s1_q  <= data_i;
            gain_s1_q  <= gain_i;
            shift_s1_q <= shift_i;
            prod_s2_q  <= prod_s2_d;
            shift_s2_q <= shift_s1_q;
            q_s3_q     <= q_s3_d;
            clip_s3_q  <= clip_s3_d;
            y_s4_q     <= y_s4_d;
            sat_s4_q   <= clip_s3_q;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign data_o    = y_s4_q;
    assign sat_o     = sat_s4_q;
    assign sat_cnt_o = sat_cnt_q;
    assign state_o   = ramp_state;

endmodule

// File: tb/tb_feedback_output_stage.sv
// Scoreboard bench for feedback_output_stage: a driver pushes expected outputs
// from an arithmetic reference model, a monitor pops and compares them.
module tb_feedback_output_stage;

    localparam int IW     = 17;
    localparam int GW     = 16;
    localparam int OW     = 14;
    localparam int RB     = 8;
    localparam int CW     = 16;
    localparam int R_FULL = 1 << RB;
    localparam int Q_MAX  = (1 << (OW - 1)) - 1;
    localparam int Q_MIN  = -(1 << (OW - 1));
    localparam int C_MAX  = (1 << CW) - 1;
    localparam int S_OFF  = 0;
    localparam int S_UP   = 1;
    localparam int S_ON   = 2;
    localparam int S_DOWN = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic signed [IW-1:0]  data_i;
    logic signed [GW-1:0]  gain_i;
    logic        [3:0]     shift_i;
    logic                  enable_i;
    logic        [3:0]     ramp_rate_i;
    logic                  sat_clr_i;
    logic signed [OW-1:0]  data_o;
    logic                  sat_o;
    logic        [CW-1:0]  sat_cnt_o;
    logic        [1:0]     state_o;

    feedback_output_stage #(
        .INPUT_WIDTH   (IW),
        .GAIN_WIDTH    (GW),
        .OUTPUT_WIDTH  (OW),
        .RAMP_BITS     (RB),
        .SAT_CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .data_i      (data_i),
        .gain_i      (gain_i),
        .shift_i     (shift_i),
        .enable_i    (enable_i),
        .ramp_rate_i (ramp_rate_i),
        .sat_clr_i   (sat_clr_i),
        .data_o      (data_o),
        .sat_o       (sat_o),
        .sat_cnt_o   (sat_cnt_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int y; bit sat; int cnt; int st; } exp_s;
    typedef struct { int q; bit clip; } samp_s;

    exp_s  exp_q[$];
    samp_s pend[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model state: ramp factor, ramp mode, step timing, clip count.
    int m_r, m_state, m_phase, m_per, m_cnt;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Gain, shift with floor, then clamp to the DAC range.
    function automatic samp_s ref_sample(input int d, input int g, input int sh);
        samp_s  s;
        longint v;
        v = floor_div(longint'(d) * longint'(g), longint'(1) << sh);
        s.clip = (v > Q_MAX) || (v < Q_MIN);
        s.q    = (v > Q_MAX) ? Q_MAX : (v < Q_MIN) ? Q_MIN : int'(v);
        return s;
    endfunction

    task automatic model_reset();
        samp_s z;
        z.q = 0; z.clip = 1'b0;
        m_r = 0; m_state = S_OFF; m_phase = 0; m_per = 1; m_cnt = 0;
        pend.delete();
        exp_q.delete();
        repeat (3) pend.push_back(z);
    endtask

    task automatic restart(input int rate);
        m_phase = 0;
        m_per   = 1 << rate;
    endtask

    // R moves one unit toward the level requested by enable every m_per cycles.
    task automatic ramp_step(input bit en, input int rate);
        int goal, dir;
        if (m_state == S_OFF) begin
            if (en) begin m_state = S_UP; restart(rate); end
        end else if (m_state == S_ON) begin
            if (!en) begin m_state = S_DOWN; restart(rate); end
        end else begin
            goal = (m_state == S_UP) ? R_FULL : 0;
            dir  = (m_state == S_UP) ? 1 : -1;
            if (en != (m_state == S_UP)) begin
                m_state = en ? S_UP : S_DOWN;
                restart(rate);
            end else if (m_r == goal) begin
                m_state = en ? S_ON : S_OFF;
                restart(rate);
            end else begin
                m_phase++;
                if (m_phase == m_per) begin
                    m_r = m_r + dir;
                    restart(rate);
                    if (m_r == goal) m_state = en ? S_ON : S_OFF;
                end
            end
        end
    endtask

    // Drive one cycle's inputs and push what the DUT must show after the edge.
    task automatic drive(input bit en, input int rate, input int d, input int g,
                         input int sh, input bit clr);
        exp_s  e;
        samp_s old;
        enable_i    = en;
        ramp_rate_i = 4'(rate);
        data_i      = IW'(d);
        gain_i      = GW'(g);
        shift_i     = 4'(sh);
        sat_clr_i   = clr;
        pend.push_back(ref_sample(d, g, sh));
        old   = pend.pop_front();
        e.y   = int'(floor_div(longint'(old.q) * longint'(m_r), R_FULL));
        e.sat = old.clip;
        if (clr) m_cnt = 0;
        else if (old.clip && m_state != S_OFF && m_cnt < C_MAX) m_cnt++;
        e.cnt = m_cnt;
        ramp_step(en, rate);
        e.st  = m_state;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit en, input int rate, input int d, input int g,
                         input int sh, input bit clr);
        @(negedge clk_i);
        drive(en, rate, d, g, sh, clr);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_o"}, data_o, 0);
        check({tag, "_sat_o"}, sat_o, 0);
        check({tag, "_sat_cnt_o"}, sat_cnt_o, 0);
        check({tag, "_state_o"}, state_o, S_OFF);
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
    endfunction

    function automatic int rnd_gain();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 16)) - 8;
        return int'($urandom_range(0, (1 << GW) - 1)) - (1 << (GW - 1));
    endfunction

    // Monitor: compare whatever the scoreboard expects for the edge just taken.
    initial begin
        exp_s e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_data_o", data_o, e.y);
                check("sb_sat_o", sat_o, e.sat);
                check("sb_sat_cnt_o", sat_cnt_o, e.cnt);
                check("sb_state_o", state_o, e.st);
            end
        end
    end

    initial begin
        int  n;
        bit  en;
        int  rate;

        rst_ni = 1'b1;
        enable_i = 1'b0; ramp_rate_i = '0; data_i = '0; gain_i = '0;
        shift_i = '0; sat_clr_i = 1'b0;
        #3 rst_ni = 1'b0;
        #1 check_zero("reset");
        repeat (3) @(negedge clk_i);
        model_reset();
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // OFF: R = 0 forces zero output whatever the data, and clips are not counted.
        repeat (20) cycle(0, 0, rnd_data(), rnd_gain(), $urandom_range(0, 15), 0);
        check("off_data_o", data_o, 0);

        // Ramp up at rate 0: ON is seen 256 steps after RAMP_UP starts.
        n = 0;
        do begin cycle(1, 0, 8000, 1, 0, 0); n++; end while (state_o != 2'(S_ON) && n < 2000);
        check("ramp_up_cycles_rate0", n, 2 + 256);
        repeat (4) cycle(1, 0, 8000, 1, 0, 0);
        check("ramp_final_data_o", data_o, 8000);

        // Directed datapath cases in ON.
        repeat (5) cycle(1, 0, 1000, 1, 0, 0);
        check("pass_data_o", data_o, 1000);
        check("pass_sat_o", sat_o, 0);
        cycle(1, 0, 1000, 1, 0, 1);
        repeat (8) cycle(1, 0, 20000, 1, 0, 0);
        check("sat_hi_data_o", data_o, Q_MAX);
        check("sat_hi_sat_o", sat_o, 1);
        check("sat_cnt_after_4", sat_cnt_o, 4);
        repeat (5) cycle(1, 0, -20000, 1, 0, 0);
        check("sat_lo_data_o", data_o, Q_MIN);
        cycle(1, 0, -20000, 1, 0, 1);
        cycle(1, 0, -20000, 1, 0, 0);
        check("sat_clr_cnt", sat_cnt_o, 0);
        repeat (5) cycle(1, 0, -3, 3, 1, 0);
        check("floor_data_o", data_o, -5);
        repeat (5) cycle(1, 0, 4096, -2, 0, 0);
        check("neg_edge_data_o", data_o, Q_MIN);
        check("neg_edge_sat_o", sat_o, 0);

        // Random datapath traffic in ON with occasional counter clears.
        repeat (300) cycle(1, 0, rnd_data(), rnd_gain(), $urandom_range(0, 15),
                           ($urandom_range(0, 31) == 0));

        // Drop to OFF, ramp up to R = 100, reverse and ramp back down to OFF.
        n = 0;
        while (m_state != S_OFF && n < 5000) begin cycle(0, 0, 8000, 1, 0, 0); n++; end
        n = 0;
        while (m_r != 100 && n < 5000) begin cycle(1, 0, 8000, 1, 0, 0); n++; end
        check("reach_r100", m_r, 100);
        n = 0;
        while (m_state != S_OFF && n < 5000) begin cycle(0, 0, 8000, 1, 0, 0); n++; end
        repeat (6) cycle(0, 0, 8000, 1, 0, 0);
        check("after_down_data_o", data_o, 0);
        check("after_down_state_o", state_o, S_OFF);

        // Ramp up at rate 2 takes 1024 cycles.
        n = 0;
        do begin cycle(1, 2, 8000, 1, 0, 0); n++; end while (state_o != 2'(S_ON) && n < 3000);
        check("ramp_up_cycles_rate2", n, 2 + 1024);

        // Random enable toggling and live rate changes.
        en = 1'b1; rate = 2;
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) rate = $urandom_range(0, 3);
            cycle(en, rate, rnd_data(), rnd_gain(), $urandom_range(0, 15),
                  ($urandom_range(0, 127) == 0));
        end

        // Reset mid RAMP_UP with a full pipeline of clipping samples.
        n = 0;
        while (m_state != S_OFF && n < 40000) begin cycle(0, 0, 0, 0, 0, 0); n++; end
        repeat (60) cycle(1, 1, 20000, 1, 0, 0);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_zero("midreset");
        repeat (2) @(negedge clk_i);
        model_reset();
        rst_ni = 1'b1;
        drive(1, 1, 20000, 1, 0, 0);
        repeat (40) cycle(1, 1, 20000, 1, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 0, 0);

        @(posedge clk_i);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
